ohs_boost_pwm_gen: RTL

PWM modulator that feeds the level-1 boost converter model. It generates the switch gate `S1_pwm` and the model integration strobe `ce` from a Q-format duty command. Duty and period changes are double-buffered and take effect only at carrier period boundaries, so the model never sees a truncated or glitched pulse.

---
 rtl/ohs_boost_pkg.sv | 16 +
 rtl/ohs_boost_ce_gen.sv | 28 ++
 rtl/ohs_boost_pwm_gen.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ohs_boost_pkg.sv
// Shared constants and types for the level-1 boost converter PWM front end.
package ohs_boost_pkg;

  localparam int unsigned DEF_DATA_WIDTH    = 32;
  localparam int unsigned DEF_Q_WIDTH       = 22;
  localparam int unsigned DEF_COUNTER_WIDTH = 16;
  localparam int unsigned DEF_CE_DIV_WIDTH  = 8;

  localparam logic [DEF_DATA_WIDTH-1:0] ONE = DEF_DATA_WIDTH'(1) << DEF_Q_WIDTH;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } carrier_dir_e;

endpackage

// File: rtl/ohs_boost_ce_gen.sv
// Model step strobe prescaler: ce pulses once every ce_div+1 clocks, free-running.
module ohs_boost_ce_gen
  import ohs_boost_pkg::*;
#(
  parameter int unsigned CE_DIV_WIDTH = DEF_CE_DIV_WIDTH
) (
  input  logic                    aclk,
  input  logic                    resetn,
  input  logic [CE_DIV_WIDTH-1:0] ce_div,
  output logic                    ce
);

  logic [CE_DIV_WIDTH-1:0] ce_cnt;
  logic                    ce_hit;

  assign ce_hit = (ce_cnt == ce_div);

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      ce_cnt <= '0;
      ce     <= 1'b0;
    end else begin
      ce_cnt <= ce_hit ? '0 : ce_cnt + CE_DIV_WIDTH'(1);
      ce     <= ce_hit;
    end
  end

endmodule

// File: rtl/ohs_boost_pwm_gen.sv
// Double-buffered PWM modulator for the boost model; center-aligned carrier
// when OHS_BOOST_PWM_CENTER_ALIGNED_EN is defined, edge-aligned otherwise.
module ohs_boost_pwm_gen
  import ohs_boost_pkg::*;
#(
  parameter int unsigned MODEL_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MODEL_Q_WIDTH    = DEF_Q_WIDTH,
  parameter int unsigned COUNTER_WIDTH    = DEF_COUNTER_WIDTH,
  parameter int unsigned CE_DIV_WIDTH     = DEF_CE_DIV_WIDTH
) (
  input  logic                        aclk,
  input  logic                        resetn,
  input  logic                        enable,
  input  logic [CE_DIV_WIDTH-1:0]     ce_div,
  input  logic [COUNTER_WIDTH-1:0]    period,
  input  logic [MODEL_DATA_WIDTH-1:0] duty,
  output logic                        ce,
  output logic                        S1_pwm,
  output logic                        sync,
  output logic [COUNTER_WIDTH-1:0]    cmp_active
);

  localparam int unsigned DW = MODEL_DATA_WIDTH;
  localparam int unsigned CW = COUNTER_WIDTH;
  localparam int unsigned PW = MODEL_DATA_WIDTH + COUNTER_WIDTH;
  localparam logic [DW-1:0] one_q = DW'(1) << MODEL_Q_WIDTH;

  logic [DW-1:0] duty_sat;
  logic [PW-1:0] prod;
  logic [CW-1:0] cmp_next;
  logic [CW-1:0] period_a;
  logic [CW-1:0] cnt, cnt_next, top;
  logic          period_ok, run, wrap, wrap_q, load;

  ohs_boost_ce_gen #(.CE_DIV_WIDTH(CE_DIV_WIDTH)) u_ce_gen (
    .aclk   (aclk),
    .resetn (resetn),
    .ce_div (ce_div),
    .ce     (ce)
  );

  always_comb begin
    if (duty[DW-1])         duty_sat = '0;
    else if (duty > one_q)  duty_sat = one_q;
    else                    duty_sat = duty;
  end

  assign prod     = PW'(duty_sat) * PW'(period);
  assign cmp_next = CW'(prod >> MODEL_Q_WIDTH);

  assign period_ok = (period_a >= CW'(2));
  assign run       = enable && period_ok;
  assign top       = period_a - CW'(1);

`ifdef OHS_BOOST_PWM_CENTER_ALIGNED_EN
  carrier_dir_e dir, dir_next;

  always_ff @(posedge aclk) begin
    if (!resetn) dir <= DIR_UP;
    else         dir <= dir_next;
  end

  // Each end value is held for one extra tick so a period is exactly 2*period_a ticks.
  always_comb begin
    dir_next = dir;
    cnt_next = cnt;
    wrap     = 1'b0;
    if (!run) begin
      dir_next = DIR_UP;
      cnt_next = '0;
    end else if (ce) begin
      unique case (dir)
        DIR_UP: begin
          if (cnt == top) dir_next = DIR_DOWN;
          else            cnt_next = cnt + CW'(1);
        end
        DIR_DOWN: begin
          if (cnt == '0) begin
            dir_next = DIR_UP;
            wrap     = 1'b1;
          end else begin
            cnt_next = cnt - CW'(1);
          end
        end
      endcase
    end
  end
`else
  always_comb begin
    cnt_next = cnt;
    wrap     = 1'b0;
    if (!run) begin
      cnt_next = '0;
    end else if (ce) begin
      if (cnt == top) begin
        cnt_next = '0;
        wrap     = 1'b1;
      end else begin
        cnt_next = cnt + CW'(1);
      end
    end
  end
`endif

  // A short period never wraps, so it reloads on every ce to let a new period take over.
  assign load = !enable || (ce && (!period_ok || wrap));

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      cnt        <= '0;
      period_a   <= '0;
      cmp_active <= '0;
      S1_pwm     <= 1'b0;
      wrap_q     <= 1'b0;
      sync       <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      S1_pwm <= run && (cnt < cmp_active);
      // Delayed one clock so sync lines up with the gate for the first tick.
      wrap_q <= wrap;
      sync   <= wrap_q && enable;
      if (load) begin
        period_a   <= period;
        cmp_active <= cmp_next;
      end
    end
  end

endmodule
